// File: rtl/dsp_mac_sequencer_pkg.sv
// Shared definitions for the DSP MAC sequencer.
// Holds the FSM state encoding, slice timing constants, datapath widths and
// the tap-count clamp helper used when a job is latched.
package dsp_mac_sequencer_pkg;

    localparam int SAMPLE_W   = 27;
    localparam int RESULT_W   = 64;
    localparam int TAPS_W     = 4;
    localparam int COEF_SEL_W = 3;
    localparam int MUX_SEL_W  = 5;
    localparam int DRAIN_W    = 2;

    // Cycles from the last accumulate input to a valid slice result.
    localparam int SLICE_LAT = 4;
    localparam int MAX_TAPS  = 8;

    // ay path direct, coefficient bank selected.
    localparam logic [MUX_SEL_W-1:0] MUX_SEL_COEF = 5'b10001;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ACC   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } seq_state_e;

    function automatic logic [TAPS_W-1:0] clamp_taps(input logic [TAPS_W-1:0] taps);
        logic [TAPS_W-1:0] r;
        r = taps;
        if (taps > TAPS_W'(MAX_TAPS)) begin
            r = TAPS_W'(MAX_TAPS);
        end
        return r;
    endfunction

endpackage

// File: rtl/dsp_slice.sv
// Behavioural multiply-accumulate DSP slice driven by dsp_mac_sequencer.
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   clr              - synchronous accumulator clear (active high)
//   loadconst        - load const_in into the accumulator
//   accumulate       - add (or subtract when negate=1) ay * coefficient
//   ay, coefsela     - sample operand and coefficient bank index
//   mux_sel          - 5'b10001 selects the coefficient bank, else multiply by 1
//   const_in         - constant loaded by loadconst
//   resulta          - accumulator value after a 3-stage output pipeline
// The accumulator register plus three output stages give a 4-cycle latency
// from the last accumulate input to resulta.
module dsp_slice (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        loadconst,
    input  logic        accumulate,
    input  logic        negate,
    input  logic [26:0] ay,
    input  logic [2:0]  coefsela,
    input  logic [4:0]  mux_sel,
    input  logic [63:0] const_in,
    output logic [63:0] resulta
);

    logic [63:0] p_q, p_d;
    logic [63:0] s1_q, s2_q, s3_q;
    logic [63:0] coef;
    logic [63:0] mult;
    logic [63:0] prod;

    always_comb begin
        // Coefficient bank: 0x21111, 0x22222, ... 0x28888.
        coef = 64'h21111 + (64'h1111 * 64'(coefsela));
        mult = (mux_sel == 5'b10001) ? coef : 64'd1;
        prod = 64'(ay) * mult;
        p_d  = p_q;
        if (clr) begin
            p_d = '0;
        end else if (loadconst) begin
            p_d = const_in;
        end else if (accumulate) begin
            p_d = negate ? (p_q - prod) : (p_q + prod);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q  <= '0;
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            p_q  <= p_d;
            s1_q <= p_q;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign resulta = s3_q;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Sequencer that runs one multiply-accumulate job on an external DSP slice.
// A job (tap count, bias, negate flag) is accepted in IDLE; the slice is
// loaded with the bias, then one sample per tap is streamed in, the slice
// pipeline is drained and the result is presented on the m_* stream.
// Ports:
//   clk, clr_n                    - clock, asynchronous active-low reset
//   job_valid/job_ready, job_*    - job request handshake and job fields
//   s_valid/s_ready/s_data        - 27-bit sample stream (consumed in ACC)
//   m_valid/m_ready/m_data        - 64-bit result stream (offered in DONE)
//   busy                          - high whenever not IDLE
//   dsp_*                         - slice controls; dsp_resulta is slice output
//   dbg_state                     - current FSM state
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; the producer holds data stable while valid is high and ready low.
module dsp_mac_sequencer
    import dsp_mac_sequencer_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [TAPS_W-1:0]     job_taps,
    input  logic [RESULT_W-1:0]   job_bias,
    input  logic                  job_neg,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [SAMPLE_W-1:0]   s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RESULT_W-1:0]   m_data,
    output logic                  busy,
    output logic [SAMPLE_W-1:0]   dsp_ay,
    output logic [COEF_SEL_W-1:0] dsp_coefsela,
    output logic [MUX_SEL_W-1:0]  dsp_mux_sel,
    output logic                  dsp_loadconst,
    output logic                  dsp_accumulate,
    output logic                  dsp_negate,
    output logic [RESULT_W-1:0]   dsp_constant,
    output logic                  dsp_clr,
    input  logic [RESULT_W-1:0]   dsp_resulta,
    output seq_state_e            dbg_state
);

    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(SLICE_LAT - 1);

    seq_state_e            state_q, state_d;
    logic [TAPS_W-1:0]     taps_q, taps_d;
    logic [RESULT_W-1:0]   bias_q, bias_d;
    logic                  neg_q, neg_d;
    logic [TAPS_W-1:0]     tap_idx_q, tap_idx_d;
    logic [DRAIN_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [RESULT_W-1:0]   m_data_q, m_data_d;

    always_comb begin
        state_d        = state_q;
        taps_d         = taps_q;
        bias_d         = bias_q;
        neg_d          = neg_q;
        tap_idx_d      = tap_idx_q;
        drain_cnt_d    = drain_cnt_q;
        m_data_d       = m_data_q;
        job_ready      = 1'b0;
        s_ready        = 1'b0;
        m_valid        = 1'b0;
        dsp_ay         = '0;
        dsp_coefsela   = '0;
        dsp_loadconst  = 1'b0;
        dsp_accumulate = 1'b0;
        dsp_negate     = 1'b0;
        dsp_constant   = '0;
        dsp_clr        = 1'b0;

        case (state_q)
            IDLE: begin
                job_ready = 1'b1;
                // Keep the slice cleared so nothing stale survives into a job.
                dsp_clr   = 1'b1;
                if (job_valid) begin
                    taps_d  = clamp_taps(job_taps);
                    bias_d  = job_bias;
                    neg_d   = job_neg;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                dsp_loadconst = 1'b1;
                dsp_constant  = bias_q;
                tap_idx_d     = '0;
                drain_cnt_d   = '0;
                state_d       = (taps_q == '0) ? DRAIN : ACC;
            end
            ACC: begin
                s_ready        = 1'b1;
                // Accumulate stays high during bubbles; ay=0 adds nothing.
                dsp_accumulate = 1'b1;
                dsp_negate     = neg_q;
                dsp_coefsela   = tap_idx_q[COEF_SEL_W-1:0];
                if (s_valid) begin
                    dsp_ay = s_data;
                    if (tap_idx_q == taps_q - 4'd1) begin
                        tap_idx_d = '0;
                        state_d   = DRAIN;
                    end else begin
                        tap_idx_d = tap_idx_q + 4'd1;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    m_data_d    = dsp_resulta;
                    drain_cnt_d = '0;
                    state_d     = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            DONE: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            taps_q      <= '0;
            bias_q      <= '0;
            neg_q       <= 1'b0;
            tap_idx_q   <= '0;
            drain_cnt_q <= '0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            taps_q      <= taps_d;
            bias_q      <= bias_d;
            neg_q       <= neg_d;
            tap_idx_q   <= tap_idx_d;
            drain_cnt_q <= drain_cnt_d;
            m_data_q    <= m_data_d;
        end
    end

    assign dsp_mux_sel = MUX_SEL_COEF;
    assign busy        = (state_q != IDLE);
    assign m_data      = m_data_q;
    assign dbg_state   = state_q;

endmodule
